// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants and helpers for the stream_mux_n slice.
//   MODE_FIXED / MODE_RR : values of the 'mode' input.
//   sel_width(n)         : channel-index width, at least 1 bit.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// stream_mux_n_if: bundle of the producer and consumer handshake signals of
// stream_mux_n.
//   slave  modport : the mux view (drives in_ready and the out_* beat).
//   master modport : the environment view (drives mode/sel, the inputs and
//                    out_ready).
// Channel i data is in_data[i*W +: W].
interface stream_mux_n_if
    import stream_mux_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
);
    localparam int SELW = sel_width(N);

    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_ready;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic [SELW-1:0]   out_ch;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_last, out_ch, out_valid
    );

    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_last, out_ch, out_valid
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req     [N]    : request vector
//   ptr     [SELW] : highest-priority index (must be < N)
//   gnt     [N]    : one-hot grant, first request at or after ptr, wrapping
//   gnt_idx [SELW] : encoded grant index (0 when nothing is requested)
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N    = 16,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx
);

    int unsigned     pos;
    logic [SELW-1:0] idx;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr < N, so a single subtraction is enough for the wrap
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = SELW'(pos);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-to-1 valid/ready stream multiplexer with a registered
// output stage. Channel chosen by 'sel' (mode=0) or round-robin (mode=1).
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : mode, sel, in_data/in_valid/in_last -> in_ready,
//                  out_data/out_last/out_ch/out_valid <- out_ready
// Optional feature macro STREAM_MUX_PKT_LOCK_EN: once a non-last beat is
// taken from a channel the grant stays on it until its last beat.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_mux_n_if.slave     bus
);

    localparam int SELW = sel_width(N);

    logic [W-1:0]    ch_data [N];
    logic [SELW-1:0] ptr;
    logic [N-1:0]    rr_gnt;
    logic [SELW-1:0] rr_idx;
    logic [N-1:0]    grant;
    logic [SELW-1:0] gidx;
    logic            load;
    logic            xfer;
    logic [SELW-1:0] ptr_next;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic            locked;
    logic [SELW-1:0] lock_ch;
`endif

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign ch_data[i] = bus.in_data[i*W +: W];
    end

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        grant = '0;
        gidx  = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (locked) begin
            grant[lock_ch] = bus.in_valid[lock_ch];
            gidx           = lock_ch;
        end else
`endif
        if (bus.mode == MODE_RR) begin
            grant = rr_gnt;
            gidx  = rr_idx;
        end else if (32'(bus.sel) < N) begin
            grant[bus.sel] = bus.in_valid[bus.sel];
            gidx           = bus.sel;
        end
    end

    assign load         = !bus.out_valid || bus.out_ready;
    // grant already implies in_valid, so any ready bit is a transfer
    assign bus.in_ready = grant & {N{load && rst_n}};
    assign xfer         = |bus.in_ready;
    assign ptr_next     = (gidx == SELW'(N - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_ch    <= '0;
            ptr           <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            locked        <= 1'b0;
            lock_ch       <= '0;
`endif
        end else begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= ch_data[gidx];
                bus.out_last  <= bus.in_last[gidx];
                bus.out_ch    <= gidx;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

`ifdef STREAM_MUX_PKT_LOCK_EN
            if (xfer) begin
                if (bus.in_last[gidx]) begin
                    locked <= 1'b0;
                    if (bus.mode == MODE_RR) begin
                        ptr <= ptr_next;
                    end
                end else begin
                    locked  <= 1'b1;
                    lock_ch <= gidx;
                end
            end
`else
            if (xfer && bus.mode == MODE_RR) begin
                ptr <= ptr_next;
            end
`endif
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;

`ifdef STREAM_MUX_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic r12;
    always #5 clk = ~clk;

    stream_mux_n_if #(.N(16), .W(8)) m16 ();
    stream_mux_n_if #(.N(12), .W(8)) m12 ();

    stream_mux_n #(.N(16), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m16)
    );

    stream_mux_n #(.N(12), .W(8)) dut12 (
        .clk   (clk),
        .rst_n (r12),
        .bus   (m12)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference state for the N=16 instance
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_last;
    bit [3:0] m_ch;
    int       m_ptr;
    bit       m_lock;
    int       m_lock_ch;

    // channel that would be served this cycle, -1 if none
    function automatic int model_grant();
        int g = -1;
        if (!rst_n) return -1;
        if (m_valid && !m16.out_ready) return -1;
        if (LOCK_EN && m_lock) begin
            if (m16.in_valid[m_lock_ch]) g = m_lock_ch;
        end else if (m16.mode) begin
            for (int k = 0; k < 16; k++)
                if (g < 0 && m16.in_valid[(m_ptr + k) % 16]) g = (m_ptr + k) % 16;
        end else if (m16.in_valid[m16.sel]) begin
            g = int'(m16.sel);
        end
        return g;
    endfunction

    function automatic logic [15:0] model_ready();
        logic [15:0] r = '0;
        int g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_last = 0; m_ch = 0;
        m_ptr = 0; m_lock = 0; m_lock_ch = 0;
    endtask

    // advance the reference with the current inputs, then clock the DUT
    task automatic cycle();
        int g = model_grant();
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_valid = 1;
            m_data  = m16.in_data[g*8 +: 8];
            m_last  = m16.in_last[g];
            m_ch    = 4'(g);
            if (LOCK_EN) begin
                if (m16.in_last[g]) begin
                    m_lock = 0;
                    if (m16.mode) m_ptr = (g + 1) % 16;
                end else begin
                    m_lock = 1;
                    m_lock_ch = g;
                end
            end else if (m16.mode) begin
                m_ptr = (g + 1) % 16;
            end
        end else if (m16.out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_data();
        for (int k = 0; k < 16; k++) m16.in_data[k*8 +: 8] = 8'(8'h10 + k);
    endtask

    task automatic test_reset();
        rst_n = 0;
        m16.mode = 0; m16.sel = 0; m16.in_data = '0;
        m16.in_valid = '1; m16.in_last = '1; m16.out_ready = 1;
        #1;
        vectors++;
        if (m16.in_ready !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_in_ready got %h want 0000", m16.in_ready);
        end
        cycle();
        cycle();
        vectors++;
        if ({m16.out_valid, m16.out_data, m16.out_last, m16.out_ch} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b d=%h l=%b ch=%0d want all 0",
                     m16.out_valid, m16.out_data, m16.out_last, m16.out_ch);
        end
        rst_n = 1;
    endtask

    task automatic test_fixed();
        logic [3:0]  sels [3];
        logic [15:0] want_rdy;
        sels = '{4'h0, 4'h6, 4'hc};
        fill_data();
        m16.mode = 0; m16.in_valid = '1; m16.in_last = '1; m16.out_ready = 1;
        foreach (sels[i]) begin
            m16.sel = sels[i];
            #1;
            want_rdy = '0;
            want_rdy[sels[i]] = 1'b1;
            vectors++;
            if (m16.in_ready !== want_rdy) begin
                miscompares++;
                $display("FAIL fixed_ready sel=%0d got %h want %h", sels[i], m16.in_ready, want_rdy);
            end
            cycle();
            vectors++;
            if (m16.out_valid !== 1'b1 || m16.out_data !== 8'(8'h10 + sels[i]) || m16.out_ch !== sels[i]) begin
                miscompares++;
                $display("FAIL fixed_out sel=%0d got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         sels[i], m16.out_valid, m16.out_data, m16.out_ch, 8'(8'h10 + sels[i]), sels[i]);
            end
        end
    endtask

    task automatic test_rr_fair();
        int exp_seq [6] = '{2, 5, 9, 2, 5, 9};
        m16.mode = 1; m16.in_valid = 16'h0224; m16.in_last = '1; m16.out_ready = 1;
        fill_data();
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (!$onehot(m16.in_ready) || m16.in_ready !== model_ready()) begin
                miscompares++;
                $display("FAIL rr_ready beat %0d got %h want %h", i, m16.in_ready, model_ready());
            end
            cycle();
            vectors++;
            if (m16.out_valid !== 1'b1 || int'(m16.out_ch) != exp_seq[i]) begin
                miscompares++;
                $display("FAIL rr_order beat %0d got v=%b ch=%0d want v=1 ch=%0d",
                         i, m16.out_valid, m16.out_ch, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] beats [3] = '{8'hA5, 8'h3C, 8'h77};
        logic [7:0] got [$];
        int si = 0;
        bit will_send, will_recv;
        logic [7:0] cap;
        m16.mode = 0; m16.sel = 4'd3; m16.in_valid = '0; m16.in_last = '1; m16.out_ready = 1;
        cycle();
        for (int c = 0; c < 8; c++) begin
            m16.out_ready = (c >= 4);
            m16.in_valid = '0;
            m16.in_valid[3] = (si < 3);
            m16.in_data[3*8 +: 8] = (si < 3) ? beats[si] : 8'h00;
            #1;
            vectors++;
            if (m16.in_ready !== model_ready() || (c >= 1 && c <= 3 && m16.in_ready[3] !== 1'b0)) begin
                miscompares++;
                $display("FAIL bp_ready cycle %0d got %h want %h", c, m16.in_ready, model_ready());
            end
            will_send = m16.in_ready[3];
            will_recv = m16.out_valid && m16.out_ready;
            cap = m16.out_data;
            cycle();
            if (will_send) si++;
            if (will_recv) got.push_back(cap);
            vectors++;
            if ({m16.out_valid, m16.out_data, m16.out_last, m16.out_ch} !== {m_valid, m_data, m_last, m_ch} ||
                (c <= 3 && (m16.out_valid !== 1'b1 || m16.out_data !== 8'hA5))) begin
                miscompares++;
                $display("FAIL bp_out cycle %0d got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                         c, m16.out_valid, m16.out_data, m16.out_ch, m_valid, m_data, m_ch);
            end
        end
        vectors++;
        if (got.size() != 3 || got[0] !== 8'hA5 || got[1] !== 8'h3C || got[2] !== 8'h77) begin
            miscompares++;
            $display("FAIL bp_stream got %0d beats %p want A5 3C 77", got.size(), got);
        end
    endtask

    task automatic test_pkt_lock();
        int exp_lock [5] = '{1, 1, 1, 0, 0};
        int exp_free [5] = '{1, 0, 1, 0, 1};
        int b = 0;
        bit sent1;
        m16.mode = 1; m16.out_ready = 1; m16.in_last = '1;
        m16.in_valid = 16'h0001; m16.in_data[7:0] = 8'hC0;
        cycle();  // moves the pointer to 1
        for (int c = 0; c < 5; c++) begin
            m16.in_valid = 16'h0001;
            m16.in_valid[1] = (b < 3);
            m16.in_last[1] = (b == 2);
            m16.in_data[15:8] = 8'(8'hB0 + b);
            #1;
            sent1 = m16.in_ready[1];
            cycle();
            if (sent1) b++;
            vectors++;
            if (int'(m16.out_ch) != (LOCK_EN ? exp_lock[c] : exp_free[c]) || m16.out_ch !== m_ch ||
                m16.out_data !== m_data || m16.out_last !== m_last) begin
                miscompares++;
                $display("FAIL pkt_order beat %0d got ch=%0d d=%h want ch=%0d d=%h",
                         c, m16.out_ch, m16.out_data, LOCK_EN ? exp_lock[c] : exp_free[c], m_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        m16.mode = 1; m16.out_ready = 1; m16.in_valid = 16'h0010; m16.in_last = '0;
        cycle();
        rst_n = 0;
        m16.in_valid = '1;
        #1;
        vectors++;
        if (m16.in_ready !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_ready got %h want 0000", m16.in_ready);
        end
        cycle();
        vectors++;
        if (m16.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_valid got %b want 0", m16.out_valid);
        end
        rst_n = 1;
        m16.in_last = '1;
        #1;
        vectors++;
        if (m16.in_ready !== 16'h0001) begin
            miscompares++;
            $display("FAIL rstmid_restart_ready got %h want 0001", m16.in_ready);
        end
        cycle();
        vectors++;
        if (m16.out_valid !== 1'b1 || m16.out_ch !== 4'd0) begin
            miscompares++;
            $display("FAIL rstmid_restart got v=%b ch=%0d want v=1 ch=0", m16.out_valid, m16.out_ch);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            m16.mode = (c < 200) ? 1'b1 : 1'($urandom_range(0, 1));
            m16.sel = 4'($urandom_range(0, 15));
            m16.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            m16.in_valid = 16'($urandom()) & 16'($urandom());
            m16.in_last = 16'($urandom()) | 16'($urandom());
            m16.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (m16.in_ready !== model_ready()) begin
                miscompares++;
                $display("FAIL rand_ready cycle %0d got %h want %h", c, m16.in_ready, model_ready());
            end
            cycle();
            vectors++;
            if ({m16.out_valid, m16.out_data, m16.out_last, m16.out_ch} !== {m_valid, m_data, m_last, m_ch}) begin
                miscompares++;
                $display("FAIL rand_out cycle %0d got v=%b d=%h l=%b ch=%0d want v=%b d=%h l=%b ch=%0d",
                         c, m16.out_valid, m16.out_data, m16.out_last, m16.out_ch,
                         m_valid, m_data, m_last, m_ch);
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 12; k++) m12.in_data[k*8 +: 8] = 8'(8'h40 + k);
        m12.mode = 0; m12.sel = 4'd2; m12.in_valid = '1; m12.in_last = '1; m12.out_ready = 1;
        @(posedge clk); #1;
        r12 = 1;
        @(posedge clk); #1;
        vectors++;
        if (m12.out_valid !== 1'b1 || m12.out_ch !== 4'd2 || m12.out_data !== 8'h42) begin
            miscompares++;
            $display("FAIL oor_prime got v=%b ch=%0d d=%h want v=1 ch=2 d=42", m12.out_valid, m12.out_ch, m12.out_data);
        end
        m12.sel = 4'd11;
        #1;
        vectors++;
        if (m12.in_ready !== 12'h800) begin
            miscompares++;
            $display("FAIL oor_edge_ready got %h want 800", m12.in_ready);
        end
        m12.sel = 4'hd;
        #1;
        vectors++;
        if (m12.in_ready !== 12'h000) begin
            miscompares++;
            $display("FAIL oor_ready got %h want 000", m12.in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (m12.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_drain got v=%b want 0", m12.out_valid);
        end
    endtask

    initial begin
        rst_n = 0;
        r12 = 0;
        m12.mode = 0; m12.sel = '0; m12.in_data = '0;
        m12.in_valid = '0; m12.in_last = '0; m12.out_ready = 0;
        model_reset();
        test_reset();
        test_fixed();
        test_rr_fair();
        test_backpressure();
        test_pkt_lock();
        test_reset_mid();
        test_random();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
